// File: rtl/spi_regs_pkg.sv
// Shared definitions for the synchronous SPI register bank.
// Holds the frame-width derivation, the position of the R/W flag,
// the FSM state encoding and the indices of the control registers
// that the top level consumes (LED, mux select, DAC control).
package spi_regs_pkg;

  // Control register indices used by the top level
  localparam int REG_LED = 7;
  localparam int REG_MUX = 8;
  localparam int REG_DAC = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } spi_state_t;

  // A frame is one address byte followed by one data word
  function automatic int frame_w(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

  // The R/W flag is the MSB of the address field
  function automatic int rw_bit(input int addr_w);
    return addr_w - 1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for one asynchronous SPI pin, with a history
// flop that yields single-clk rise/fall pulses on the synchronised copy.
// Ports:
//   clk, rst_n : system clock, synchronous active-low reset
//   din        : asynchronous pin
//   level      : synchronised level
//   rise, fall : one-clk pulses on synchronised edges
// All stages reset low. For chip select this means a frame that is
// already in progress (pin low) at reset release produces no falling
// edge and is therefore ignored until CS is next asserted.
module spi_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  // sync_r[0..1] synchronise, sync_r[2] holds the previous synchronised value
  logic [2:0] sync_r;

  // Synchroniser and edge-history shift chain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r <= 3'b000;
    end else begin
      sync_r <= {sync_r[1:0], din};
    end
  end

  assign level = sync_r[1];
  assign rise  = sync_r[1] & ~sync_r[2];
  assign fall  = ~sync_r[1] & sync_r[2];

endmodule

// File: rtl/spi_reg_bank_sync.sv
// SPI-slave (mode 1) register bank with readback, fully in the clk domain.
// Frame = R/W flag, register index, data word (MSB first). Writes commit
// only for frames of exactly FRAME_W bits to an implemented register.
// Ports:
//   clk, rst_n         : system clock, synchronous active-low reset
//   spi_clk, spi_cs_n  : SPI SCK (CPOL=0) and chip select, asynchronous
//   special_n          : bank select, sampled only when CS is asserted
//   spi_mosi/spi_miso  : serial data in/out
//   miso_oe            : high while a selected frame is shifting
//   regs_flat          : all registers, register i at [i*DATA_W +: DATA_W]
//   wr_strobe/wr_index : commit pulse and index of the last write
//   frame_err          : pulse when a selected frame is rejected
module spi_reg_bank_sync
  import spi_regs_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int NREGS  = 16,
  parameter logic [NREGS*DATA_W-1:0] RST_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      spi_clk,
  input  logic                      spi_cs_n,
  input  logic                      special_n,
  input  logic                      spi_mosi,
  output logic                      spi_miso,
  output logic                      miso_oe,
  output logic [NREGS*DATA_W-1:0]   regs_flat,
  output logic                      wr_strobe,
  output logic [ADDR_W-2:0]         wr_index,
  output logic                      frame_err
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int RW_POS  = rw_bit(ADDR_W);
  localparam int IDX_W   = ADDR_W - 1;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam int OCNT_W  = $clog2(DATA_W + 1);
  localparam int RA_W    = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ADDR_M1 = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0]  CNT_FRAME   = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0]  CNT_SAT     = CNT_W'(FRAME_W + 1);
  localparam logic [OCNT_W-1:0] OCNT_ONE    = OCNT_W'(1);
  localparam logic [OCNT_W-1:0] OCNT_FULL   = OCNT_W'(DATA_W);
  localparam logic [IDX_W:0]    NREGS_C     = (IDX_W + 1)'(NREGS);

  // Synchronised pins and edge pulses
  logic sck_lvl_s, sck_rise_s, sck_fall_s;
  logic cs_lvl_s, cs_rise_s, cs_fall_s;
  logic mosi_s, mosi_rise_s, mosi_fall_s;
  logic special_s, special_rise_s, special_fall_s;
  logic unused_s;

  spi_sync_edge u_sck  (.clk(clk), .rst_n(rst_n), .din(spi_clk),
                        .level(sck_lvl_s), .rise(sck_rise_s), .fall(sck_fall_s));
  spi_sync_edge u_cs   (.clk(clk), .rst_n(rst_n), .din(spi_cs_n),
                        .level(cs_lvl_s), .rise(cs_rise_s), .fall(cs_fall_s));
  spi_sync_edge u_mosi (.clk(clk), .rst_n(rst_n), .din(spi_mosi),
                        .level(mosi_s), .rise(mosi_rise_s), .fall(mosi_fall_s));
  spi_sync_edge u_spec (.clk(clk), .rst_n(rst_n), .din(special_n),
                        .level(special_s), .rise(special_rise_s), .fall(special_fall_s));

  assign unused_s = ^{sck_lvl_s, cs_lvl_s, mosi_rise_s, mosi_fall_s,
                      special_rise_s, special_fall_s};

  // State
  spi_state_t         state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [FRAME_W-1:0] shift_r;
  logic [DATA_W-1:0]  out_r;
  logic [OCNT_W-1:0]  out_left_r;
  logic               miso_r;
  logic               oe_r;
  logic               wr_strobe_r;
  logic               frame_err_r;
  logic [IDX_W-1:0]   wr_index_r;
  logic [DATA_W-1:0]  regs_r [NREGS];

  // Address field as it stands once the bit being sampled has shifted in;
  // used to preload read data on the last address bit.
  logic [ADDR_W-1:0]  addr_next_s;
  logic [IDX_W-1:0]   rd_idx_s;
  logic               rd_hit_s;
  logic [DATA_W-1:0]  rd_data_s;

  assign addr_next_s = {shift_r[ADDR_W-2:0], mosi_s};
  assign rd_idx_s    = addr_next_s[IDX_W-1:0];
  assign rd_hit_s    = ({1'b0, rd_idx_s} < NREGS_C);
  assign rd_data_s   = rd_hit_s ? regs_r[rd_idx_s[RA_W-1:0]] : {DATA_W{1'b0}};

  // Completed frame fields
  logic               frame_rw_s;
  logic [IDX_W-1:0]   frame_idx_s;
  logic [DATA_W-1:0]  frame_data_s;
  logic               frame_hit_s;
  logic               commit_wr_s;
  logic               commit_err_s;

  assign frame_rw_s   = shift_r[FRAME_W-1];
  assign frame_idx_s  = shift_r[FRAME_W-2:DATA_W];
  assign frame_data_s = shift_r[DATA_W-1:0];
  assign frame_hit_s  = ({1'b0, frame_idx_s} < NREGS_C);

  // Commit decision for the frame that has just ended
  always_comb begin
    commit_wr_s  = 1'b0;
    commit_err_s = 1'b0;
    if (state_r == COMMIT) begin
      if (cnt_r != CNT_FRAME) begin
        commit_err_s = 1'b1;
      end else if (frame_rw_s) begin
        commit_wr_s  = 1'b0;
        commit_err_s = 1'b0;
      end else if (frame_hit_s) begin
        commit_wr_s = 1'b1;
      end else begin
        commit_err_s = 1'b1;
      end
    end else begin
      commit_wr_s  = 1'b0;
      commit_err_s = 1'b0;
    end
  end

  // Frame FSM: shifting, read preload, MISO drive and commit pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      shift_r     <= '0;
      out_r       <= '0;
      out_left_r  <= '0;
      miso_r      <= 1'b0;
      oe_r        <= 1'b0;
      wr_strobe_r <= 1'b0;
      frame_err_r <= 1'b0;
      wr_index_r  <= '0;
    end else begin
      wr_strobe_r <= 1'b0;
      frame_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cs_fall_s && !special_s) begin
            state_r    <= SHIFT;
            cnt_r      <= '0;
            shift_r    <= '0;
            out_r      <= '0;
            out_left_r <= '0;
            miso_r     <= 1'b0;
            oe_r       <= 1'b1;
          end
        end
        SHIFT: begin
          // CS deassertion takes priority; a coincident SCK edge is dropped
          if (cs_rise_s) begin
            state_r <= COMMIT;
            oe_r    <= 1'b0;
            miso_r  <= 1'b0;
          end else if (sck_fall_s) begin
            shift_r <= {shift_r[FRAME_W-2:0], mosi_s};
            if (cnt_r != CNT_SAT) begin
              cnt_r <= cnt_r + CNT_ONE;
            end
            if ((cnt_r == CNT_ADDR_M1) && addr_next_s[RW_POS]) begin
              out_r      <= rd_data_s;
              out_left_r <= OCNT_FULL;
            end
          end else if (sck_rise_s) begin
            if (out_left_r != '0) begin
              miso_r     <= out_r[DATA_W-1];
              out_r      <= {out_r[DATA_W-2:0], 1'b0};
              out_left_r <= out_left_r - OCNT_ONE;
            end else begin
              miso_r <= 1'b0;
            end
          end
        end
        COMMIT: begin
          state_r     <= IDLE;
          wr_strobe_r <= commit_wr_s;
          frame_err_r <= commit_err_s;
          if (commit_wr_s) begin
            wr_index_r <= frame_idx_s;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Register array: reset image and committed writes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= RST_VAL[i*DATA_W +: DATA_W];
      end
    end else if (commit_wr_s) begin
      regs_r[frame_idx_s[RA_W-1:0]] <= frame_data_s;
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs_r[g];
  end

  assign spi_miso  = miso_r;
  assign miso_oe   = oe_r;
  assign wr_strobe = wr_strobe_r;
  assign wr_index  = wr_index_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_spi_reg_bank_sync.sv
// Scoreboard bench for spi_reg_bank_sync: stimulus pushes expected commit
// pulses and readback words into queues; independent monitors pop and
// compare when the DUT pulses wr_strobe/frame_err or a read frame ends.
module tb_spi_reg_bank_sync;

  localparam logic [127:0] TB_RST = 128'hAFAE_ADAC_ABAA_A9A8_A7A6_A5A4_A3A2_A1A0;
  localparam logic [1:0] KIND_WR  = 2'b01;
  localparam logic [1:0] KIND_ERR = 2'b10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         spi_clk = 1'b0;
  logic         spi_cs_n = 1'b1;
  logic         special_n = 1'b1;
  logic         spi_mosi = 1'b0;
  logic         spi_miso;
  logic         miso_oe;
  logic [127:0] regs_flat;
  logic         wr_strobe;
  logic [6:0]   wr_index;
  logic         frame_err;

  spi_reg_bank_sync #(
    .ADDR_W(8), .DATA_W(8), .NREGS(16), .RST_VAL(TB_RST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
    .special_n(special_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .miso_oe(miso_oe), .regs_flat(regs_flat), .wr_strobe(wr_strobe),
    .wr_index(wr_index), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] kind;
    logic [6:0] idx;
    logic [7:0] val;
  } evt_t;

  typedef struct {
    int          frame;
    logic [15:0] word;
  } rd_t;

  evt_t         exp_evt_q[$];
  rd_t          exp_rd_q[$];
  logic [127:0] model_flat;
  int           total = 0;
  int           bad = 0;
  int           frame_no = 0;
  logic [15:0]  cap = 16'h0000;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every commit pulse must match the next expected event
  always @(negedge clk) begin
    evt_t e;
    if (rst_n && (wr_strobe || frame_err)) begin
      if (exp_evt_q.size() == 0) begin
        check("unexpected_pulse", {126'd0, frame_err, wr_strobe}, 128'd0);
      end else begin
        e = exp_evt_q.pop_front();
        check("pulse_kind", {126'd0, frame_err, wr_strobe}, {126'd0, e.kind});
        if (e.kind == KIND_WR) begin
          check("wr_index", {121'd0, wr_index}, {121'd0, e.idx});
          check("wr_value", {120'd0, regs_flat[e.idx*8 +: 8]}, {120'd0, e.val});
        end
      end
    end
  end

  // Monitor: capture MISO at every master sampling edge of a frame
  always @(negedge spi_cs_n) begin
    cap = 16'h0000;
    frame_no++;
  end

  always @(negedge spi_clk) begin
    if (!spi_cs_n) cap = {cap[14:0], spi_miso};
  end

  always @(posedge spi_cs_n) begin
    rd_t r;
    if (exp_rd_q.size() > 0 && exp_rd_q[0].frame == frame_no) begin
      r = exp_rd_q.pop_front();
      check("miso_word", {112'd0, cap}, {112'd0, r.word});
    end
  end

  task automatic exp_wr(input logic [6:0] idx, input logic [7:0] val);
    exp_evt_q.push_back('{kind: KIND_WR, idx: idx, val: val});
    model_flat[idx*8 +: 8] = val;
  endtask

  task automatic exp_err();
    exp_evt_q.push_back('{kind: KIND_ERR, idx: 7'd0, val: 8'd0});
  endtask

  task automatic exp_rd(input logic [15:0] word);
    exp_rd_q.push_back('{frame: frame_no + 1, word: word});
  endtask

  // One SPI mode-1 frame: MOSI changes with SCK rising, slave samples on falling.
  // rst_after > 0 pulses rst_n for one clk after that many bits.
  task automatic send_frame(input logic [15:0] word, input int nbits,
                            input logic sel_n, input int rst_after);
    special_n = sel_n;
    repeat (4) @(posedge clk);
    spi_cs_n = 1'b0;
    repeat (6) @(posedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = (i < 16) ? word[15-i] : 1'b0;
      spi_clk = 1'b1;
      repeat (6) @(posedge clk);
      if (i == 0) begin
        #1;
        check("miso_oe_in_frame", {127'd0, miso_oe}, {127'd0, ~sel_n});
      end
      spi_clk = 1'b0;
      repeat (6) @(posedge clk);
      if (i + 1 == rst_after) begin
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
      end
    end
    spi_cs_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("miso_oe_after", {127'd0, miso_oe}, 128'd0);
    check("miso_after", {127'd0, spi_miso}, 128'd0);
    check("pulses_pending", exp_evt_q.size(), 128'd0);
    special_n = 1'b1;
  endtask

  initial begin
    model_flat = TB_RST;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_regs", regs_flat, TB_RST);
    check("rst_wr_strobe", {127'd0, wr_strobe}, 128'd0);
    check("rst_frame_err", {127'd0, frame_err}, 128'd0);
    check("rst_miso_oe", {127'd0, miso_oe}, 128'd0);
    check("rst_miso", {127'd0, spi_miso}, 128'd0);
    check("rst_wr_index", {121'd0, wr_index}, 128'd0);

    // Write LED register
    exp_wr(7'd7, 8'h03);
    send_frame(16'h0703, 16, 1'b0, 0);
    check("regs_w7", regs_flat, model_flat);

    // Write DAC register, then read it back
    exp_wr(7'd9, 8'h0A);
    send_frame(16'h090A, 16, 1'b0, 0);
    exp_rd(16'h000A);
    send_frame(16'h8900, 16, 1'b0, 0);
    check("regs_rd9", regs_flat, model_flat);

    // Short and overrun frames to the mux register
    exp_err();
    send_frame(16'h08FF, 15, 1'b0, 0);
    exp_err();
    send_frame(16'h08FF, 17, 1'b0, 0);
    check("regs_bad_len", regs_flat, model_flat);

    // Out-of-range index: write rejected, read returns zero without error
    exp_err();
    send_frame(16'h2055, 16, 1'b0, 0);
    exp_rd(16'h0000);
    send_frame(16'hA000, 16, 1'b0, 0);
    check("regs_oor", regs_flat, model_flat);

    // Bank not selected: frame ignored entirely
    send_frame(16'h075A, 16, 1'b1, 0);
    check("regs_unselected", regs_flat, model_flat);

    // Reset after bit 10 aborts the frame and restores the reset image
    send_frame(16'h07C3, 16, 1'b0, 10);
    model_flat = TB_RST;
    check("regs_mid_reset", regs_flat, model_flat);
    check("wr_index_mid_reset", {121'd0, wr_index}, 128'd0);

    // Normal operation after reset
    exp_wr(7'd8, 8'h3C);
    send_frame(16'h083C, 16, 1'b0, 0);
    exp_rd(16'h003C);
    send_frame(16'h8800, 16, 1'b0, 0);
    exp_rd(16'h00A7);
    send_frame(16'h8700, 16, 1'b0, 0);
    check("regs_final", regs_flat, model_flat);
    check("wr_index_final", {121'd0, wr_index}, 128'd8);

    check("evt_q_empty", exp_evt_q.size(), 128'd0);
    check("rd_q_empty", exp_rd_q.size(), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
